// File: rtl/cycle_drive_sched.sv
// Multi-channel cycle-delay drive scheduler with skewed input sampling.
// Optional per-channel queue flush is enabled by defining CDS_FLUSH_EN.
module cycle_drive_sched #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int DLY_W    = 4,
  parameter int IN_SKEW  = 1,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [CW-1:0]             req_chan,
  input  logic [WIDTH-1:0]          req_data,
  input  logic [DLY_W-1:0]          req_delay,
  output logic [CHANNELS*WIDTH-1:0] drv_data,
  output logic [CHANNELS-1:0]       drv_strobe,
  output logic [CHANNELS-1:0]       busy,
`ifdef CDS_FLUSH_EN
  input  logic [CHANNELS-1:0]       flush,
`endif
  input  logic [CHANNELS*WIDTH-1:0] smp_in,
  output logic [CHANNELS*WIDTH-1:0] smp_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_COUNT = 1'b1;

  logic [CHANNELS-1:0] full;
  logic [(2**CW)-1:0]  full_ext;
  logic                accept;

  // Unused channel codes read as full so a request to them is never accepted.
  for (genvar gi = 0; gi < 2**CW; gi++) begin : g_full
    if (gi < CHANNELS) begin : g_real
      assign full_ext[gi] = full[gi];
    end else begin : g_pad
      assign full_ext[gi] = 1'b1;
    end
  end

  assign req_ready = reset_n && !full_ext[req_chan];
  assign accept    = req_valid && req_ready;

  for (genvar gc = 0; gc < CHANNELS; gc++) begin : g_chan
    logic [WIDTH-1:0] q_data [DEPTH];
    logic [DLY_W-1:0] q_dly  [DEPTH];
    logic [PW-1:0]    rd;
    logic [PW-1:0]    wr;
    logic [PW-1:0]    rd_next;
    logic [OW-1:0]    occ;
    logic             state;
    logic [DLY_W-1:0] cnt;
    logic [WIDTH-1:0] dout;
    logic             stb;
    logic             push;
    logic             pop;
    logic             fl;

`ifdef CDS_FLUSH_EN
    assign fl = flush[gc];
`else
    assign fl = 1'b0;
`endif

    assign push    = accept && (req_chan == CW'(gc));
    assign pop     = (state == ST_COUNT) && (cnt == '0);
    assign rd_next = rd + 1'b1;
    assign full[gc] = (occ == OW'(DEPTH));

    // The head entry's delay lives in cnt; later entries load theirs only
    // once the previous one has driven, giving sequential relative delays.
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        state <= ST_IDLE;
        cnt   <= '0;
        rd    <= '0;
        wr    <= '0;
        occ   <= '0;
        dout  <= '0;
        stb   <= 1'b0;
      end else if (fl) begin
        state <= ST_IDLE;
        cnt   <= '0;
        rd    <= '0;
        wr    <= '0;
        occ   <= '0;
        stb   <= 1'b0;
      end else begin
        stb <= 1'b0;
        if (push) begin
          q_data[wr] <= req_data;
          q_dly[wr]  <= req_delay;
          wr         <= wr + 1'b1;
        end
        occ <= occ + OW'(push) - OW'(pop);
        case (state)
          ST_IDLE: begin
            if (push) begin
              state <= ST_COUNT;
              cnt   <= req_delay;
            end
          end
          default: begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else begin
              dout <= q_data[rd];
              stb  <= 1'b1;
              rd   <= rd_next;
              if (occ > OW'(1)) begin
                cnt <= q_dly[rd_next];
              end else if (push) begin
                cnt <= req_delay;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
        endcase
      end
    end

    assign drv_data[gc*WIDTH +: WIDTH] = dout;
    assign drv_strobe[gc]              = stb;
    assign busy[gc]                    = (occ != '0) || (state == ST_COUNT);
  end

  if (IN_SKEW == 0) begin : g_noskew
    assign smp_out = smp_in;
  end else begin : g_skew
    logic [CHANNELS*WIDTH-1:0] stg [IN_SKEW];

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        for (int i = 0; i < IN_SKEW; i++) stg[i] <= '0;
      end else begin
        stg[0] <= smp_in;
        for (int i = 1; i < IN_SKEW; i++) stg[i] <= stg[i-1];
      end
    end

    assign smp_out = stg[IN_SKEW-1];
  end

endmodule

// File: tb/tb_cycle_drive_sched.sv
// Scoreboard bench for cycle_drive_sched: expected drives are queued per
// channel with their due edge and retired when the strobe appears.
module tb_cycle_drive_sched;
  localparam int CHANNELS = 4;
  localparam int WIDTH    = 8;
  localparam int DEPTH    = 4;
  localparam int DLY_W    = 4;
  localparam int IN_SKEW  = 2;

  logic                      clock = 1'b0;
  logic                      reset_n;
  logic                      req_valid;
  logic                      req_ready;
  logic [1:0]                req_chan;
  logic [WIDTH-1:0]          req_data;
  logic [DLY_W-1:0]          req_delay;
  logic [CHANNELS*WIDTH-1:0] drv_data;
  logic [CHANNELS-1:0]       drv_strobe;
  logic [CHANNELS-1:0]       busy;
  logic [CHANNELS-1:0]       flush;
  logic [CHANNELS*WIDTH-1:0] smp_in;
  logic [CHANNELS*WIDTH-1:0] smp_out;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               due;
  } exp_t;

  exp_t expq [CHANNELS][$];
  int   last_due [CHANNELS];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  logic mon_exp;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  cycle_drive_sched #(
    .CHANNELS(CHANNELS), .WIDTH(WIDTH), .DEPTH(DEPTH),
    .DLY_W(DLY_W), .IN_SKEW(IN_SKEW)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_chan(req_chan),
    .req_data(req_data),
    .req_delay(req_delay),
    .drv_data(drv_data),
    .drv_strobe(drv_strobe),
    .busy(busy),
`ifdef CDS_FLUSH_EN
    .flush(flush),
`endif
    .smp_in(smp_in),
    .smp_out(smp_out)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic clearModel();
    for (int c = 0; c < CHANNELS; c++) begin
      expq[c].delete();
      last_due[c] = 0;
    end
  endtask

  // Drives one request for one edge; a drive is expected one edge after the
  // later of its accept edge and the previous drive on that channel, plus delay.
  task automatic applyStimulus(input int ch, input logic [WIDTH-1:0] data,
                               input int dly, input bit exp_ready);
    exp_t e;
    int   k;
    @(negedge clock);
    #1;
    req_valid = 1'b1;
    req_chan  = ch[1:0];
    req_data  = data;
    req_delay = dly[DLY_W-1:0];
    #1;
    checkOutput($sformatf("ready_ch%0d_at%0d", ch, cyc), {63'd0, req_ready}, {63'd0, exp_ready});
    if (exp_ready) begin
      k      = cyc + 1;
      e.data = data;
      e.due  = ((k > last_due[ch]) ? k : last_due[ch]) + 1 + dly;
      last_due[ch] = e.due;
      expq[ch].push_back(e);
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  // Every edge, each channel's strobe must match whether its queue head is due.
  always @(negedge clock) begin
    for (int c = 0; c < CHANNELS; c++) begin
      mon_exp = (expq[c].size() > 0) && (expq[c][0].due == cyc);
      checkOutput($sformatf("strobe%0d_at%0d", c, cyc), {63'd0, drv_strobe[c]}, {63'd0, mon_exp});
      if (mon_exp) begin
        checkOutput($sformatf("data%0d_at%0d", c, cyc),
                    {56'd0, drv_data[c*WIDTH +: WIDTH]}, {56'd0, expq[c][0].data});
        void'(expq[c].pop_front());
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_chan  = '0;
    req_data  = '0;
    req_delay = '0;
    flush     = '0;
    smp_in    = '0;
    clearModel();

    waitCycles(3);
    $display("[TB] reset state");
    checkOutput("rst_ready",  {63'd0, req_ready}, 64'd0);
    checkOutput("rst_data",   {32'd0, drv_data}, 64'd0);
    checkOutput("rst_strobe", {60'd0, drv_strobe}, 64'd0);
    checkOutput("rst_busy",   {60'd0, busy}, 64'd0);
    checkOutput("rst_smp",    {32'd0, smp_out}, 64'd0);
    reset_n = 1'b1;

    $display("[TB] channel 0 delay 0");
    applyStimulus(0, 8'hA5, 0, 1'b1);
    waitCycles(2);
    checkOutput("ch0_data", {56'd0, drv_data[7:0]}, 64'hA5);
    waitCycles(1);
    checkOutput("ch0_hold", {56'd0, drv_data[7:0]}, 64'hA5);
    checkOutput("ch0_stb_off", {63'd0, drv_strobe[0]}, 64'd0);

    $display("[TB] channel 1 delay 10");
    applyStimulus(1, 8'h3C, 10, 1'b1);
    for (int i = 0; i <= 10; i++) begin
      waitCycles(1);
      checkOutput($sformatf("ch1_busy_%0d", i), {63'd0, busy[1]}, 64'd1);
    end
    waitCycles(1);
    checkOutput("ch1_idle", {63'd0, busy[1]}, 64'd0);
    checkOutput("ch1_data", {56'd0, drv_data[15:8]}, 64'h3C);

    $display("[TB] channel 2 fill and back-to-back drain");
    applyStimulus(2, 8'h01, 6, 1'b1);
    applyStimulus(2, 8'h02, 0, 1'b1);
    applyStimulus(2, 8'h03, 0, 1'b1);
    applyStimulus(2, 8'h04, 0, 1'b1);
    checkOutput("ch2_busy_full", {63'd0, busy[2]}, 64'd1);
    applyStimulus(2, 8'h05, 0, 1'b0);
    waitCycles(10);
    checkOutput("ch2_idle", {63'd0, busy[2]}, 64'd0);
    checkOutput("ch2_last", {56'd0, drv_data[23:16]}, 64'h04);

    $display("[TB] all channels converge");
    applyStimulus(0, 8'h11, 3, 1'b1);
    applyStimulus(1, 8'h22, 2, 1'b1);
    applyStimulus(2, 8'h33, 1, 1'b1);
    applyStimulus(3, 8'h44, 0, 1'b1);
    waitCycles(2);
    checkOutput("all_strobe", {60'd0, drv_strobe}, 64'hF);
    checkOutput("all_data", {32'd0, drv_data}, 64'h44332211);

    $display("[TB] reset mid-count");
    waitCycles(2);
    applyStimulus(0, 8'h66, 7, 1'b1);
    waitCycles(3);
    reset_n = 1'b0;
    clearModel();
    waitCycles(1);
    checkOutput("midrst_ready", {63'd0, req_ready}, 64'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      waitCycles(1);
      checkOutput($sformatf("midrst_data_%0d", i), {32'd0, drv_data}, 64'd0);
      checkOutput($sformatf("midrst_busy_%0d", i), {60'd0, busy}, 64'd0);
    end

    $display("[TB] input skew");
    smp_in = 32'h55AA33CC;
    waitCycles(1);
    checkOutput("skew_1", {32'd0, smp_out}, 64'd0);
    waitCycles(1);
    checkOutput("skew_2", {32'd0, smp_out}, 64'h55AA33CC);
    smp_in = 32'h5555_5555;
    waitCycles(2);
    checkOutput("skew_3", {32'd0, smp_out}, 64'h55555555);

`ifdef CDS_FLUSH_EN
    $display("[TB] flush before due drive");
    applyStimulus(0, 8'h77, 0, 1'b1);
    waitCycles(3);
    applyStimulus(0, 8'h99, 4, 1'b1);
    waitCycles(4);
    flush[0]  = 1'b1;
    req_valid = 1'b1;
    req_chan  = 2'd0;
    req_data  = 8'hEE;
    req_delay = '0;
    expq[0].delete();
    last_due[0] = 0;
    waitCycles(1);
    flush[0]  = 1'b0;
    req_valid = 1'b0;
    checkOutput("flush_busy", {63'd0, busy[0]}, 64'd0);
    checkOutput("flush_data", {56'd0, drv_data[7:0]}, 64'h77);
    waitCycles(4);
    checkOutput("flush_data_hold", {56'd0, drv_data[7:0]}, 64'h77);
`endif

    waitCycles(5);
    for (int c = 0; c < CHANNELS; c++) begin
      checkOutput($sformatf("drained_%0d", c), 64'(expq[c].size()), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
